// File: rtl/div_4bit_seq_pkg.sv
// Shared definitions for the sequential restoring divider: state
// encoding, default operand width, iteration counter width and the
// subtract-mode constant used by the trial subtractor.
package div_4bit_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEFAULT_W = 4;

  // A 2-bit operand still needs a 1-bit counter, so clamp $clog2 at 1.
  function automatic int count_width(input int w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

  localparam int CNT_W = count_width(DEFAULT_W);

  // M=1 selects subtract in the add/subtract datapath form:
  // invert the subtrahend and feed a carry-in of one.
  localparam logic SUB_M = 1'b1;

endpackage

// File: rtl/div_4bit_seq_if.sv
// Start/done handshake plus operand and result bus of the divider.
// The master side issues requests, the slave side is the divider.
interface div_4bit_seq_if import div_4bit_seq_pkg::*; #(
  parameter int W = DEFAULT_W
);

  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );

endinterface

// File: rtl/div_4bit_seq_trial_sub_stage.sv
// Combinational ripple subtractor used for the trial subtraction of
// each divider iteration. Subtraction is done as minuend + ~subtrahend
// + 1; a carry-out of one means the minuend was not smaller (no borrow).
module trial_sub_stage import div_4bit_seq_pkg::*; #(
  parameter int N = DEFAULT_W + 1
) (
  input  logic [N-1:0] minuend,
  input  logic [N-1:0] subtrahend,
  output logic [N-1:0] diff,
  output logic         cout
);

  logic [N-1:0] b_x;
  logic [N:0]   carry;

  assign b_x      = subtrahend ^ {N{SUB_M}};
  assign carry[0] = SUB_M;

  // One full adder per bit, carry rippling from LSB to MSB.
  for (genvar i = 0; i < N; i++) begin : g_bit
    assign diff[i]      = minuend[i] ^ b_x[i] ^ carry[i];
    assign carry[i + 1] = (minuend[i] & b_x[i]) | (carry[i] & (minuend[i] ^ b_x[i]));
  end

  assign cout = carry[N];

endmodule

// File: rtl/div_4bit_seq.sv
// Sequential restoring divider: W-bit unsigned dividend / divisor,
// one quotient bit per clock, start/done handshake. Results are held
// on the bus until the next completed operation or reset.
module div_4bit_seq import div_4bit_seq_pkg::*; #(
  parameter int W = DEFAULT_W
) (
  input  logic             clk,
  input  logic             rst,
  div_4bit_seq_if.slave    bus
);

  localparam int CW = (W == DEFAULT_W) ? CNT_W : count_width(W);
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  state_t        state_q;
  state_t        state_d;

  logic [W:0]    r_q;
  logic [W:0]    r_shift;
  logic [W:0]    r_next;
  logic [W:0]    trial;
  logic [W-1:0]  q_q;
  logic [W-1:0]  q_next;
  logic [W-1:0]  d_q;
  logic [CW-1:0] cnt_q;

  logic [W-1:0]  quotient_q;
  logic [W-1:0]  remainder_q;
  logic          dbz_q;

  logic          no_borrow;
  logic          zero_div;
  logic          last_iter;
  logic          busy;
  logic          done;

  assign zero_div  = (bus.divisor == '0);
  assign last_iter = (cnt_q == LAST);

  // Shift {R,Q} left by one: the dividend MSB moves into the remainder.
  assign r_shift = (r_q << 1) | {{W{1'b0}}, q_q[W-1]};

  trial_sub_stage #(.N(W + 1)) u_trial (
    .minuend    (r_shift),
    .subtrahend ({1'b0, d_q}),
    .diff       (trial),
    .cout       (no_borrow)
  );

  // Restoring step: keep the difference only when the subtraction fit.
  assign r_next = no_borrow ? trial : r_shift;
  assign q_next = (q_q << 1) | {{(W-1){1'b0}}, no_borrow};

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; start is only honoured outside RUN.
  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = zero_div ? DONE : RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (last_iter) begin
          state_d = DONE;
        end
      end
      DONE: begin
        done = 1'b1;
        if (bus.start) begin
          state_d = zero_div ? DONE : RUN;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Operand capture, iteration datapath and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_q         <= '0;
      q_q         <= '0;
      d_q         <= '0;
      cnt_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (bus.start) begin
            if (zero_div) begin
              quotient_q  <= '1;
              remainder_q <= bus.dividend;
              dbz_q       <= 1'b1;
            end else begin
              d_q   <= bus.divisor;
              r_q   <= '0;
              q_q   <= bus.dividend;
              cnt_q <= '0;
            end
          end
        end
        RUN: begin
          r_q   <= r_next;
          q_q   <= q_next;
          cnt_q <= cnt_q + CW'(1);
          if (last_iter) begin
            quotient_q  <= q_next;
            remainder_q <= r_next[W-1:0];
            dbz_q       <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.busy        = busy;
  assign bus.done        = done;
  assign bus.quotient    = quotient_q;
  assign bus.remainder   = remainder_q;
  assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_div_4bit_seq.sv
// Directed bench for div_4bit_seq at W=4: reset, basic division with
// latency and busy window, edge operands, divide by zero, start while
// busy, back-to-back starts, reset mid-operation and a full sweep.
module tb_div_4bit_seq;
  import div_4bit_seq_pkg::*;

  localparam int W = DEFAULT_W;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  div_4bit_seq_if #(.W(W)) bus ();

  div_4bit_seq #(.W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Hard stop in case something hangs outside the bounded waits.
  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Present operands with start for exactly one rising edge (E0);
  // returns at the falling edge after E0.
  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    bus.dividend = a;
    bus.divisor  = b;
    bus.start    = 1'b1;
    @(negedge clk);
    bus.start    = 1'b0;
  endtask

  // Count falling edges until done is seen; -1 if it never arrives.
  task automatic wait_done(output int n);
    n = 0;
    while (bus.done !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (bus.done !== 1'b1) n = -1;
  endtask

  task automatic test_reset();
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    rst          = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.busy, bus.done, bus.div_by_zero} !== 3'b000) begin
      failures++;
      $display("[TB] FAIL reset_ctrl: busy/done/dbz got %b expected 000",
               {bus.busy, bus.done, bus.div_by_zero});
    end
    checks++;
    if ({bus.quotient, bus.remainder} !== 8'h00) begin
      failures++;
      $display("[TB] FAIL reset_data: q=%0d r=%0d expected 0 0", bus.quotient, bus.remainder);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int n;
    int busy_cnt;
    applyStimulus(4'd13, 4'd3);
    n = 0;
    busy_cnt = 0;
    while (bus.done !== 1'b1 && n < 40) begin
      if (bus.busy === 1'b1) busy_cnt++;
      if (n == 1) begin
        checks++;
        if (bus.quotient !== 4'd0) begin
          failures++;
          $display("[TB] FAIL basic_hold: q during RUN got %0d expected 0", bus.quotient);
        end
      end
      @(negedge clk);
      n++;
    end
    checks++;
    if (n !== 4) begin
      failures++;
      $display("[TB] FAIL basic_latency: got %0d cycles expected 4", n);
    end
    checks++;
    if (busy_cnt !== 4 || bus.busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL basic_busy: busy cycles %0d (busy at done %b) expected 4 (0)",
               busy_cnt, bus.busy);
    end
    checks++;
    if (bus.quotient !== 4'd4 || bus.remainder !== 4'd1 || bus.div_by_zero !== 1'b0) begin
      failures++;
      $display("[TB] FAIL basic_result: q=%0d r=%0d dbz=%b expected 4 1 0",
               bus.quotient, bus.remainder, bus.div_by_zero);
    end
    @(negedge clk);
    checks++;
    if (bus.done !== 1'b0) begin
      failures++;
      $display("[TB] FAIL basic_pulse: done second cycle got %b expected 0", bus.done);
    end
  endtask

  task automatic test_edge_values();
    logic [W-1:0] va [4] = '{4'd15, 4'd0, 4'd5, 4'd15};
    logic [W-1:0] vb [4] = '{4'd1,  4'd7, 4'd9, 4'd15};
    logic [W-1:0] vq [4] = '{4'd15, 4'd0, 4'd0, 4'd1};
    logic [W-1:0] vr [4] = '{4'd0,  4'd0, 4'd5, 4'd0};
    logic [W-1:0] prev_q = 4'd4;
    int n;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(va[i], vb[i]);
      @(negedge clk);
      checks++;
      if (bus.quotient !== prev_q) begin
        failures++;
        $display("[TB] FAIL edge_hold[%0d]: q during RUN got %0d expected %0d", i, bus.quotient, prev_q);
      end
      wait_done(n);
      checks++;
      if (n !== 3 || bus.quotient !== vq[i] || bus.remainder !== vr[i]) begin
        failures++;
        $display("[TB] FAIL edge[%0d] %0d/%0d: wait=%0d q=%0d r=%0d expected wait=3 q=%0d r=%0d",
                 i, va[i], vb[i], n, bus.quotient, bus.remainder, vq[i], vr[i]);
      end
      prev_q = vq[i];
    end
  endtask

  task automatic test_div_by_zero();
    int n;
    applyStimulus(4'd9, 4'd0);
    checks++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL dbz_timing: done=%b busy=%b expected 1 0", bus.done, bus.busy);
    end
    checks++;
    if (bus.quotient !== 4'd15 || bus.remainder !== 4'd9 || bus.div_by_zero !== 1'b1) begin
      failures++;
      $display("[TB] FAIL dbz_result: q=%0d r=%0d dbz=%b expected 15 9 1",
               bus.quotient, bus.remainder, bus.div_by_zero);
    end
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      failures++;
      $display("[TB] FAIL dbz_after: busy=%b done=%b expected 0 0", bus.busy, bus.done);
    end
    applyStimulus(4'd8, 4'd2);
    wait_done(n);
    checks++;
    if (n !== 4 || bus.quotient !== 4'd4 || bus.remainder !== 4'd0 || bus.div_by_zero !== 1'b0) begin
      failures++;
      $display("[TB] FAIL dbz_clear: wait=%0d q=%0d r=%0d dbz=%b expected 4 4 0 0",
               n, bus.quotient, bus.remainder, bus.div_by_zero);
    end
  endtask

  task automatic test_ignore_start();
    int n;
    applyStimulus(4'd14, 4'd4);
    @(negedge clk);
    bus.dividend = 4'd3;
    bus.divisor  = 4'd1;
    bus.start    = 1'b1;
    @(negedge clk);
    bus.start    = 1'b0;
    wait_done(n);
    checks++;
    if (n !== 2 || bus.quotient !== 4'd3 || bus.remainder !== 4'd2) begin
      failures++;
      $display("[TB] FAIL ignore_start: wait=%0d q=%0d r=%0d expected 2 3 2",
               n, bus.quotient, bus.remainder);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    @(negedge clk);
    bus.dividend = 4'd14;
    bus.divisor  = 4'd4;
    bus.start    = 1'b1;
    @(negedge clk);
    bus.dividend = 4'd6;
    bus.divisor  = 4'd4;
    wait_done(n);
    checks++;
    if (n !== 4 || bus.quotient !== 4'd3 || bus.remainder !== 4'd2) begin
      failures++;
      $display("[TB] FAIL b2b_first: wait=%0d q=%0d r=%0d expected 4 3 2",
               n, bus.quotient, bus.remainder);
    end
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b1 || bus.done !== 1'b0 || bus.quotient !== 4'd3) begin
      failures++;
      $display("[TB] FAIL b2b_accept: busy=%b done=%b q=%0d expected 1 0 3",
               bus.busy, bus.done, bus.quotient);
    end
    bus.start = 1'b0;
    wait_done(n);
    checks++;
    if (n !== 4 || bus.quotient !== 4'd1 || bus.remainder !== 4'd2) begin
      failures++;
      $display("[TB] FAIL b2b_second: wait=%0d q=%0d r=%0d expected 4 1 2",
               n, bus.quotient, bus.remainder);
    end
  endtask

  task automatic test_reset_mid_run();
    int n;
    int done_seen;
    applyStimulus(4'd11, 4'd2);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.busy, bus.done, bus.div_by_zero, bus.quotient, bus.remainder} !== 11'd0) begin
      failures++;
      $display("[TB] FAIL midrst_outputs: busy=%b done=%b dbz=%b q=%0d r=%0d expected all 0",
               bus.busy, bus.done, bus.div_by_zero, bus.quotient, bus.remainder);
    end
    rst = 1'b0;
    done_seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1 || bus.busy === 1'b1) done_seen++;
    end
    checks++;
    if (done_seen !== 0) begin
      failures++;
      $display("[TB] FAIL midrst_abort: busy/done seen %0d times expected 0", done_seen);
    end
    applyStimulus(4'd11, 4'd2);
    wait_done(n);
    checks++;
    if (n !== 4 || bus.quotient !== 4'd5 || bus.remainder !== 4'd1) begin
      failures++;
      $display("[TB] FAIL midrst_fresh: wait=%0d q=%0d r=%0d expected 4 5 1",
               n, bus.quotient, bus.remainder);
    end
  endtask

  task automatic test_sweep();
    int n;
    int exp_n;
    logic [W-1:0] exp_q;
    logic [W-1:0] exp_r;
    logic exp_z;
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        if (b == 0) begin
          exp_q = 4'd15;
          exp_r = W'(a);
          exp_z = 1'b1;
          exp_n = 0;
        end else begin
          exp_q = W'(a / b);
          exp_r = W'(a % b);
          exp_z = 1'b0;
          exp_n = 4;
        end
        applyStimulus(W'(a), W'(b));
        wait_done(n);
        checks++;
        if (n !== exp_n || bus.quotient !== exp_q || bus.remainder !== exp_r || bus.div_by_zero !== exp_z) begin
          failures++;
          $display("[TB] FAIL sweep %0d/%0d: wait=%0d q=%0d r=%0d dbz=%b expected %0d %0d %0d %b",
                   a, b, n, bus.quotient, bus.remainder, bus.div_by_zero, exp_n, exp_q, exp_r, exp_z);
        end
        if (b != 0) begin
          checks++;
          if ((int'(bus.quotient) * b + int'(bus.remainder)) !== a || int'(bus.remainder) >= b) begin
            failures++;
            $display("[TB] FAIL sweep_invariant %0d/%0d: q*d+r=%0d r=%0d expected %0d with r<%0d",
                     a, b, int'(bus.quotient) * b + int'(bus.remainder), bus.remainder, a, b);
          end
        end
      end
    end
  endtask

  initial begin
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    test_reset();
    test_basic();
    test_edge_values();
    test_div_by_zero();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid_run();
    test_sweep();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
